// File: rtl/param_config_multiplier.sv
// Lane-partitioned iterative multiplier: one shift-add step per BUSY cycle, all lanes in parallel.
// Optional per-lane accumulate into product_o is enabled by defining PARAM_MULT_ACCUM_EN.
//
// state | meaning
// IDLE  | waiting for a request, ready_o high (except the cycle right after reset)
// BUSY  | one partial product per lane added per cycle, LW cycles
// DONE  | result held on product_o with valid_o high until ready_i
module param_config_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    input  logic [1:0]           mode_i,
    input  logic                 signed_i,
    input  logic                 acc_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o
);

    localparam int HALF = WIDTH / 2;
    localparam int QUAR = WIDTH / 4;
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [1:0]           mode_q;
    logic                 sgn_q;
    logic [2*WIDTH-1:0]   psum_q, psum_step, psum_init, product_q;
    logic [CW-1:0]        cnt_q;
    logic                 ready_q;
    logic                 accept, last_step;
    int                   lw_q, idx;

    function automatic int lw_of(input logic [1:0] mode);
        case (mode)
            2'b10:   return WIDTH;
            2'b11:   return QUAR;
            default: return HALF;
        endcase
    endfunction

    // One radix-2 step on a single lane of width lw held in the low bits of wide vectors.
    // The signed multiplier's top bit carries negative weight, so that step subtracts.
    function automatic logic [2*WIDTH-1:0] lane_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input int                 lw,
        input logic               sgn,
        input int                 bit_idx
    );
        logic [2*WIDTH-1:0] lmask, rmask, a_ext, term, r;
        logic               a_msb, b_bit;
        lmask = (ONE_P << lw) - ONE_P;
        rmask = (ONE_P << (2 * lw)) - ONE_P;
        a_msb = |(a & (ONE_W << (lw - 1)));
        b_bit = |(b & (ONE_W << bit_idx));
        a_ext = {{WIDTH{1'b0}}, a} & lmask;
        if (sgn && a_msb)
            a_ext = a_ext | ~lmask;
        term = a_ext << bit_idx;
        r = p;
        if (b_bit) begin
            if (sgn && (bit_idx == lw - 1))
                r = p - term;
            else
                r = p + term;
        end
        return r & rmask;
    endfunction

    function automatic logic [2*WIDTH-1:0] step_all(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input logic [1:0]         mode,
        input logic               sgn,
        input int                 bit_idx
    );
        logic [2*WIDTH-1:0] r, pl, lr;
        logic [WIDTH-1:0]   al, bl;
        r = '0;
        case (mode)
            2'b00: begin
                pl = '0;
                al = '0;
                bl = '0;
                pl[WIDTH-1:0] = p[WIDTH-1:0];
                al[HALF-1:0]  = a[HALF-1:0];
                bl[HALF-1:0]  = b[HALF-1:0];
                lr = lane_step(pl, al, bl, HALF, sgn, bit_idx);
                r[WIDTH-1:0] = lr[WIDTH-1:0];
            end
            2'b01: begin
                for (int k = 0; k < 2; k++) begin
                    pl = '0;
                    al = '0;
                    bl = '0;
                    pl[WIDTH-1:0] = p[k*WIDTH +: WIDTH];
                    al[HALF-1:0]  = a[k*HALF +: HALF];
                    bl[HALF-1:0]  = b[k*HALF +: HALF];
                    lr = lane_step(pl, al, bl, HALF, sgn, bit_idx);
                    r[k*WIDTH +: WIDTH] = lr[WIDTH-1:0];
                end
            end
            2'b10: begin
                r = lane_step(p, a, b, WIDTH, sgn, bit_idx);
            end
            default: begin
                for (int k = 0; k < 4; k++) begin
                    pl = '0;
                    al = '0;
                    bl = '0;
                    pl[HALF-1:0] = p[k*HALF +: HALF];
                    al[QUAR-1:0] = a[k*QUAR +: QUAR];
                    bl[QUAR-1:0] = b[k*QUAR +: QUAR];
                    lr = lane_step(pl, al, bl, QUAR, sgn, bit_idx);
                    r[k*HALF +: HALF] = lr[HALF-1:0];
                end
            end
        endcase
        return r;
    endfunction

`ifdef PARAM_MULT_ACCUM_EN
    // Accumulation seeds the iteration with the current result instead of zero.
    assign psum_init = acc_i ? product_q : '0;
`else
    logic unused_acc;
    assign psum_init  = '0;
    assign unused_acc = acc_i;
`endif

    assign accept    = (state_q == IDLE) && valid_i && ready_q;
    assign last_step = (state_q == BUSY) && (cnt_q == '0);
    assign lw_q      = lw_of(mode_q);
    assign idx       = lw_q - 1 - int'(cnt_q);
    assign psum_step = step_all(psum_q, a_q, b_q, mode_q, sgn_q, idx);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (ready_i)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            product_q <= '0;
            psum_q    <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 2'b00;
            sgn_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                a_q    <= multiplicand_i;
                b_q    <= multiplier_i;
                mode_q <= mode_i;
                sgn_q  <= signed_i;
                psum_q <= psum_init;
                cnt_q  <= CW'(lw_of(mode_i) - 1);
            end else if (state_q == BUSY) begin
                psum_q <= psum_step;
                cnt_q  <= cnt_q - 1'b1;
                if (last_step)
                    product_q <= psum_step;
            end
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = (state_q == DONE);
    assign busy_o    = (state_q == BUSY);
    assign product_o = product_q;

endmodule
